btn_debounce: RTL and testbench
===============================

# btn_debounce

Upstream conditioning stage for the FireAnt push-buttons. It synchronises the raw active-low `BTN` pins into the 50 MHz domain and debounces them against a slow tick enable, so no derived clock is needed. It emits clean levels and single-cycle press, release and long-press pulses. The speed/shift controller consumes these pulses instead of running its own per-button debounce on `counter[16]`.

## Interface
- `NUM_BTN`, 2: number of buttons.
- `TICK_DIV`, 131072: clk_50m cycles per debounce tick (2^17, about 2.6 ms).
- `PRESS_TICKS`, 20: consecutive pressed ticks needed to qualify a press (6-bit max 63).
- `REL_TICKS`, 2: consecutive released ticks needed to qualify a release.
- `LONG_TICKS`, 200: ticks held (counted from qualification) before the long-press pulse (8-bit max 255).

- `clk_50m` input 1: sole clock; one clock; reset is asynchronous and active-high.
- `rst` input 1: asynchronous, active-high reset.
- `BTN` input NUM_BTN: raw pins, active-low (0 = pressed), asynchronous to clk_50m.
- `btn_level` output NUM_BTN: debounced level, 1 = pressed.
- `press_pulse` output NUM_BTN: 1-cycle pulse on a qualified press.
- `release_pulse` output NUM_BTN: 1-cycle pulse on a qualified release.
- `long_pulse` output NUM_BTN: 1-cycle pulse, once per press, after LONG_TICKS held.

## Operation
- Synchroniser: 2 flops per bit, reset to 1 (released). `raw_p[i] = ~sync2[i]`.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for exactly one cycle when the count equals TICK_DIV-1. It is shared by all buttons.
- Per-button FSM. States: IDLE, ARMING, HELD, RELEASING.
  - IDLE: `cnt` = 0. On a tick with raw_p=1, go to ARMING with cnt=1.
  - ARMING: on a tick with raw_p=1, cnt+1. When cnt+1 == PRESS_TICKS, go to HELD, assert press_pulse, clear hold counter. On a tick with raw_p=0, return to IDLE and clear cnt.
  - HELD: btn_level=1. On a tick with raw_p=1, hold counter increments and saturates at LONG_TICKS. On the tick where it reaches LONG_TICKS, assert long_pulse (once only). On a tick with raw_p=0, go to RELEASING with cnt=1.
  - RELEASING: btn_level stays 1. On a tick with raw_p=0, cnt+1. When cnt+1 == REL_TICKS, go to IDLE, btn_level=0, assert release_pulse. On a tick with raw_p=1, return to HELD and keep the hold count.
- State only changes on tick cycles. Between ticks, raw_p is ignored.
- Counters saturate and never wrap.
- Buttons are independent. Simultaneous events on different buttons each pulse in the same cycle.
- Reset values: all outputs 0, all FSMs IDLE, all counters 0, prescaler 0.
- Reset mid-press: no pulses are generated. After reset, a still-held button must re-qualify through the full PRESS_TICKS.
- PRESS_TICKS=1 or REL_TICKS=1: qualify on the first tick, skipping ARMING/RELEASING.

## Timing
- Pin to raw_p: 2 cycles.
- All pulses are registered. They are high in the cycle after the qualifying tick and last exactly 1 cycle.
- Worst-case press latency: 2 + PRESS_TICKS·TICK_DIV + 1 cycles.
- btn_level changes in the same cycle as the corresponding press_pulse / release_pulse.

## Structure
- Shared package `btn_pkg`: FSM state enum (2 bits), default tick/threshold constants.
- Sub-module `btn_fsm`: one instance per button via generate. It holds the FSM, cnt, and hold counter.
- The top level holds the synchroniser, prescaler and generate loop.

## Test plan
Bench parameters: TICK_DIV=4, PRESS_TICKS=3, REL_TICKS=2, LONG_TICKS=5.
- Clean press on BTN[0] held 40 cycles, then released: exactly one press_pulse[0] about 12 cycles after the pin edge, and exactly one release_pulse[0] about 8 cycles after release. btn_level[0] tracks between them.
- Bounce: BTN[0] toggles every 5 cycles for 30 cycles, then stays high: no press_pulse, btn_level stays 0.
- Long hold, 100 cycles: press_pulse, then one long_pulse 5 ticks (20 cycles) later. No repeat. release_pulse on release.
- Release glitch of 1 tick while HELD: no release_pulse. btn_level stays 1 and hold count is preserved.
- Both buttons pressed on the same cycle: press_pulse = 2'b11 in a single cycle.
- rst asserted mid-ARMING and again mid-HELD: outputs go to 0 immediately. A held pin needs a full 3 ticks again before press_pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encoding, counter widths and default timing constants.
package btn_pkg;

    // Per-button debounce FSM state (2-bit encoding).
    typedef logic [1:0] btn_state_t;

    localparam btn_state_t StIdle      = 2'd0;
    localparam btn_state_t StArming    = 2'd1;
    localparam btn_state_t StHeld      = 2'd2;
    localparam btn_state_t StReleasing = 2'd3;

    // Qualification counter and hold counter widths.
    localparam int unsigned CntW  = 6;
    localparam int unsigned HoldW = 8;

    // Defaults: 2^17 cycles of 50 MHz per tick (about 2.6 ms).
    localparam int unsigned DefTickDiv    = 131072;
    localparam int unsigned DefPressTicks = 20;
    localparam int unsigned DefRelTicks   = 2;
    localparam int unsigned DefLongTicks  = 200;

endpackage

// File: rtl/btn_fsm.sv
// Debounce FSM for one button. Advances only on tick cycles and produces a
// registered level plus single-cycle press, release and long-press pulses.
module btn_fsm
    import btn_pkg::*;
#(
    parameter int unsigned PRESS_TICKS = DefPressTicks,
    parameter int unsigned REL_TICKS   = DefRelTicks,
    parameter int unsigned LONG_TICKS  = DefLongTicks
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic raw_p_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic [CntW-1:0]  PressCnt = CntW'(PRESS_TICKS);
    localparam logic [CntW-1:0]  RelCnt   = CntW'(REL_TICKS);
    localparam logic [HoldW-1:0] LongCnt  = HoldW'(LONG_TICKS);

    btn_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    // Next-state logic; nothing moves except on a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        // Saturating increments so the counters never wrap.
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        hold_inc  = hold_q + HoldW'(1);

        if (tick_i) begin
            case (state_q)
                StIdle: begin
                    if (raw_p_i) begin
                        if (PRESS_TICKS <= 1) begin
                            state_d = StHeld;
                            press_d = 1'b1;
                            cnt_d   = '0;
                            hold_d  = '0;
                        end else begin
                            state_d = StArming;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StArming: begin
                    if (raw_p_i) begin
                        if (cnt_inc == PressCnt) begin
                            state_d = StHeld;
                            press_d = 1'b1;
                            cnt_d   = '0;
                            hold_d  = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (raw_p_i) begin
                        // Hold count stops at LongCnt, so long_d fires once per press.
                        if (hold_q != LongCnt) begin
                            hold_d = hold_inc;
                            long_d = (hold_inc == LongCnt);
                        end
                    end else if (REL_TICKS <= 1) begin
                        state_d   = StIdle;
                        release_d = 1'b1;
                        cnt_d     = '0;
                        hold_d    = '0;
                    end else begin
                        state_d = StReleasing;
                        cnt_d   = CntW'(1);
                    end
                end
                default: begin  // StReleasing
                    if (!raw_p_i) begin
                        if (cnt_inc == RelCnt) begin
                            state_d   = StIdle;
                            release_d = 1'b1;
                            cnt_d     = '0;
                            hold_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Glitch rejected: resume the press with its hold count intact.
                        state_d = StHeld;
                        cnt_d   = '0;
                    end
                end
            endcase
        end

        level_d = (state_d == StHeld) || (state_d == StReleasing);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning: synchronises raw active-low pins, generates a
// shared debounce tick and runs one debounce FSM per button.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN     = 2,
    parameter int unsigned TICK_DIV    = DefTickDiv,
    parameter int unsigned PRESS_TICKS = DefPressTicks,
    parameter int unsigned REL_TICKS   = DefRelTicks,
    parameter int unsigned LONG_TICKS  = DefLongTicks
) (
    input  logic               clk_50m,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse
);

    localparam int unsigned       PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] raw_p;
    logic [PrescW-1:0]  presc_q, presc_d;
    logic               tick;

    // Synchroniser shift and prescaler wrap.
    always_comb begin
        sync1_d = BTN;
        sync2_d = sync1_q;
        tick    = (presc_q == PrescMax);
        presc_d = tick ? '0 : presc_q + PrescW'(1);
    end

    // Synchroniser resets to released (pins high); prescaler restarts at 0.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            presc_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
        end
    end

    assign raw_p = ~sync2_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_fsm #(
            .PRESS_TICKS(PRESS_TICKS),
            .REL_TICKS  (REL_TICKS),
            .LONG_TICKS (LONG_TICKS)
        ) u_fsm (
            .clk_i    (clk_50m),
            .rst_i    (rst),
            .tick_i   (tick),
            .raw_p_i  (raw_p[i]),
            .level_o  (btn_level[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .long_o   (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with TICK_DIV=4, PRESS_TICKS=3,
// REL_TICKS=2, LONG_TICKS=5. Samples are taken on the falling edge; j counts
// falling edges since the last reset release, so the prescaler equals j%4 and
// FSM updates happen on rising edges where j%4 wraps to 0.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b11;
    logic [1:0] lvl, pp, rp, lp;

    always #5 clk = ~clk;

    btn_debounce #(
        .NUM_BTN    (2),
        .TICK_DIV   (4),
        .PRESS_TICKS(3),
        .REL_TICKS  (2),
        .LONG_TICKS (5)
    ) dut (
        .clk_50m      (clk),
        .rst          (rst),
        .BTN          (btn),
        .btn_level    (lvl),
        .press_pulse  (pp),
        .release_pulse(rp),
        .long_pulse   (lp)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int j        = 0;
    int j0;
    int n_press[2], n_rel[2], n_long[2], n_low[2];
    int last_press[2], last_rel[2], last_long[2];
    int both_cnt;
    int bad_lvl  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_low[i] = 0;
            last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
        end
        both_cnt = 0;
    endtask

    // Advance n cycles, logging pulses and level per falling-edge sample.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            j++;
            for (int i = 0; i < 2; i++) begin
                if (pp[i] === 1'b1) begin
                    n_press[i]++; last_press[i] = j;
                    if (lvl[i] !== 1'b1) bad_lvl++;
                end
                if (rp[i] === 1'b1) begin
                    n_rel[i]++; last_rel[i] = j;
                    if (lvl[i] !== 1'b0) bad_lvl++;
                end
                if (lp[i] === 1'b1) begin
                    n_long[i]++; last_long[i] = j;
                end
                if (lvl[i] !== 1'b1) n_low[i]++;
            end
            if (pp === 2'b11) both_cnt++;
        end
    endtask

    // Bring j to 1 mod 4 so a pin edge driven now is first seen by a tick 3 edges later.
    task automatic align();
        while (j % 4 != 1) cyc(1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_level"}, 32'(lvl), 32'd0);
        chk({tag, "_pulses"}, 32'({pp, rp, lp}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        j   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        repeat (2) @(negedge clk);
        chk("reset_level", 32'(lvl), 32'd0);
        chk("reset_pulses", 32'({pp, rp, lp}), 32'd0);
        rst = 1'b0;
        j   = 0;

        // Clean press held 40 cycles, then release.
        align(); j0 = j;
        btn[0] = 1'b0;
        cyc(40);
        chk("clean_press_count", 32'(n_press[0]), 32'd1);
        chk("clean_press_time", 32'(last_press[0] - j0), 32'd11);
        chk("clean_level_held", 32'(lvl[0]), 32'd1);
        chk("clean_long_time", 32'(last_long[0] - j0), 32'd31);
        chk("clean_btn1_idle", 32'(n_press[1]), 32'd0);
        j0 = j;
        btn[0] = 1'b1;
        cyc(16);
        chk("clean_release_count", 32'(n_rel[0]), 32'd1);
        chk("clean_release_time", 32'(last_rel[0] - j0), 32'd7);
        chk("clean_level_low", 32'(lvl[0]), 32'd0);

        // Bounce: 5-cycle toggles never give 3 consecutive pressed ticks.
        clr();
        for (int s = 0; s < 6; s++) begin
            btn[0] = s[0];
            cyc(5);
        end
        cyc(20);
        chk("bounce_press", 32'(n_press[0]), 32'd0);
        chk("bounce_level", 32'(n_low[0]), 32'd50);
        chk("bounce_release", 32'(n_rel[0]), 32'd0);

        // Long hold for 100 cycles: one long pulse 5 ticks after qualification.
        clr(); align(); j0 = j;
        btn[0] = 1'b0;
        cyc(100);
        chk("long_press_time", 32'(last_press[0] - j0), 32'd11);
        chk("long_count", 32'(n_long[0]), 32'd1);
        chk("long_time", 32'(last_long[0] - last_press[0]), 32'd20);
        btn[0] = 1'b1;
        cyc(16);
        chk("long_release", 32'(n_rel[0]), 32'd1);
        chk("long_no_repeat", 32'(n_long[0]), 32'd1);

        // One-tick release glitch while held: hold count survives.
        clr(); align(); j0 = j;
        btn[0] = 1'b0;
        cyc(20);
        chk("glitch_press", 32'(last_press[0] - j0), 32'd11);
        clr();
        btn[0] = 1'b1;
        cyc(4);
        btn[0] = 1'b0;
        cyc(20);
        chk("glitch_no_release", 32'(n_rel[0]), 32'd0);
        chk("glitch_level_held", 32'(n_low[0]), 32'd0);
        chk("glitch_long_count", 32'(n_long[0]), 32'd1);
        chk("glitch_long_time", 32'(last_long[0] - j0), 32'd39);
        btn[0] = 1'b1;
        cyc(16);
        chk("glitch_final_release", 32'(n_rel[0]), 32'd1);

        // Both buttons pressed together.
        clr(); align(); j0 = j;
        btn = 2'b00;
        cyc(16);
        chk("both_same_cycle", 32'(both_cnt), 32'd1);
        chk("both_press1_time", 32'(last_press[1] - j0), 32'd11);
        btn = 2'b11;
        cyc(12);
        chk("both_release", 32'({n_rel[1][1:0], n_rel[0][1:0]}), 32'h5);
        chk("both_no_long", 32'(n_long[0] + n_long[1]), 32'd0);

        // Reset mid-ARMING, then mid-HELD: full requalification each time.
        clr(); align();
        btn[0] = 1'b0;
        cyc(6);
        do_reset("rst_arming");
        clr();
        cyc(20);
        chk("rst_arming_press_count", 32'(n_press[0]), 32'd1);
        chk("rst_arming_press_time", 32'(last_press[0]), 32'd12);
        chk("rst_arming_level", 32'(lvl[0]), 32'd1);
        do_reset("rst_held");
        clr();
        cyc(16);
        chk("rst_held_press_time", 32'(last_press[0]), 32'd12);
        chk("rst_held_no_release", 32'(n_rel[0]), 32'd0);
        btn[0] = 1'b1;
        cyc(16);
        chk("rst_held_release", 32'(n_rel[0]), 32'd1);

        chk("pulse_level_alignment", 32'(bad_lvl), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
